// File: rtl/alu_result_checker_pkg.sv
// Shared types for the ALU result checker: opcode and checker-state encodings,
// plus the default-width expectation entry.
package pkg_testbench_defs;

  localparam int unsigned ALU_DATA_WIDTH = 8;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOT = 4'd5,
    ALU_SHL = 4'd6,
    ALU_SHR = 4'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_ERROR  = 2'd3
  } checker_state_t;

  typedef struct packed {
    logic                      skip;
    logic                      carry;
    logic                      zero;
    logic [ALU_DATA_WIDTH-1:0] data;
  } exp_entry_t;

endpackage

// File: rtl/alu_expect_fifo.sv
// In-order expectation FIFO; caller guarantees push is only asserted when
// not full or when a pop happens in the same cycle.
module alu_expect_fifo
  import pkg_testbench_defs::*;
#(
  parameter int unsigned WIDTH = $bits(exp_entry_t),
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // Storage needs no reset: pointers and count alone define validity.
  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_checker.sv
// Snoops ALU issues, queues golden results and scores each returned result
// against the oldest expectation; keeps counters, sticky errors and first-fail capture.
module alu_result_checker
  import pkg_testbench_defs::*;
#(
  parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    issue_valid,
  input  logic [3:0]              issue_opcode,
  input  logic [DATA_WIDTH-1:0]   issue_a,
  input  logic [DATA_WIDTH-1:0]   issue_b,
  input  logic                    res_valid,
  input  logic [DATA_WIDTH-1:0]   res_data,
  input  logic                    res_carry,
  input  logic                    res_zero,
  output logic [CNT_WIDTH-1:0]    pass_count,
  output logic [CNT_WIDTH-1:0]    fail_count,
  output logic [CNT_WIDTH-1:0]    skip_count,
  output logic [$clog2(DEPTH):0]  outstanding,
  output logic                    err_overflow,
  output logic                    err_underflow,
  output logic                    mismatch_seen,
  output logic [DATA_WIDTH+1:0]   first_exp,
  output logic [DATA_WIDTH+1:0]   first_got,
  output logic [1:0]              state
);

  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

  // Same field order as exp_entry_t, but sized by this instance's DATA_WIDTH.
  typedef struct packed {
    logic                  skip;
    logic                  carry;
    logic                  zero;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  function automatic entry_t golden(input logic [3:0] op,
                                    input logic [DATA_WIDTH-1:0] a,
                                    input logic [DATA_WIDTH-1:0] b);
    entry_t              e;
    logic [DATA_WIDTH:0] wide;
    e    = '0;
    wide = '0;
    case (op)
      ALU_ADD: begin
        wide    = {1'b0, a} + {1'b0, b};
        e.data  = wide[DATA_WIDTH-1:0];
        e.carry = wide[DATA_WIDTH];
      end
      ALU_SUB: begin
        e.data  = a - b;
        e.carry = (a < b);
      end
      ALU_AND: e.data = a & b;
      ALU_OR:  e.data = a | b;
      ALU_XOR: e.data = a ^ b;
      ALU_NOT: e.data = ~a;
      ALU_SHL: begin
        e.data  = {a[DATA_WIDTH-2:0], 1'b0};
        e.carry = a[DATA_WIDTH-1];
      end
      ALU_SHR: begin
        e.data  = {1'b0, a[DATA_WIDTH-1:1]};
        e.carry = a[0];
      end
      default: e.skip = 1'b1;
    endcase
    e.zero = (e.data == '0);
    return e;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  entry_t                issue_entry;
  entry_t                head;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  overflow_evt;
  logic                  underflow_evt;
  logic                  pass_evt;
  logic                  fail_evt;
  logic                  skip_evt;
  logic                  drains;
  logic [DATA_WIDTH+1:0] got_flags;
  logic [DATA_WIDTH+1:0] exp_flags;
  checker_state_t        cur_state;
  checker_state_t        next_state;

  assign issue_entry   = golden(issue_opcode, issue_a, issue_b);
  assign pop           = res_valid && !empty;
  assign push          = issue_valid && (!full || pop);
  assign overflow_evt  = issue_valid && full && !pop;
  assign underflow_evt = res_valid && empty;
  assign got_flags     = {res_carry, res_zero, res_data};
  assign exp_flags     = {head.carry, head.zero, head.data};
  assign skip_evt      = pop && head.skip;
  assign pass_evt      = pop && !head.skip && (got_flags == exp_flags);
  assign fail_evt      = pop && !head.skip && (got_flags != exp_flags);
  assign drains        = !push && ((outstanding == '0) || (outstanding == OCC_ONE && pop));
  assign state         = cur_state;

  alu_expect_fifo #(
    .WIDTH (DATA_WIDTH + 3),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (push),
    .pop     (pop),
    .wdata   (issue_entry),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .count   (outstanding)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cur_state <= ST_IDLE;
    else          cur_state <= next_state;
  end

  always_comb begin
    next_state = cur_state;
    if (clear) begin
      next_state = ST_IDLE;
    end else begin
      case (cur_state)
        ST_IDLE: begin
          if (fail_evt || overflow_evt || underflow_evt) next_state = ST_ERROR;
          else if (push)                                 next_state = ST_ACTIVE;
        end
        ST_ACTIVE, ST_DRAIN: begin
          if (fail_evt || overflow_evt || underflow_evt) next_state = ST_ERROR;
          else if (drains)                               next_state = ST_IDLE;
          else                                           next_state = ST_ACTIVE;
        end
        default: next_state = ST_ERROR;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pass_count    <= '0;
      fail_count    <= '0;
      skip_count    <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      mismatch_seen <= 1'b0;
      first_exp     <= '0;
      first_got     <= '0;
    end else if (clear) begin
      pass_count    <= '0;
      fail_count    <= '0;
      skip_count    <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      mismatch_seen <= 1'b0;
      first_exp     <= '0;
      first_got     <= '0;
    end else begin
      if (pass_evt)      pass_count    <= sat_inc(pass_count);
      if (skip_evt)      skip_count    <= sat_inc(skip_count);
      if (overflow_evt)  err_overflow  <= 1'b1;
      if (underflow_evt) err_underflow <= 1'b1;
      if (fail_evt) begin
        fail_count    <= sat_inc(fail_count);
        mismatch_seen <= 1'b1;
        if (!mismatch_seen) begin
          first_exp <= exp_flags;
          first_got <= got_flags;
        end
      end
    end
  end

endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
Synthesizable checker that sits downstream of the ALU DUT, beside the testbench top. It snoops each operation issued to the ALU and computes a golden result with carry and zero flags. The golden result waits in an in-order expectation FIFO. Each ALU result is compared with the FIFO head, and the block keeps pass/fail/skip counters, sticky error flags and a capture of the first mismatch, so the program under test can read a verdict without a software scoreboard.

Parameters:
DATA_WIDTH, 8, operand/result width
DEPTH, 8, expectation FIFO depth (power of 2, >=2)
CNT_WIDTH, 16, width of each counter

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
clear  in  1  synchronous soft clear of FIFO, counters, errors and state
issue_valid  in  1  an operation is presented to the ALU this cycle
issue_opcode  in  4  ALU opcode (alu_op_t)
issue_a  in  DATA_WIDTH  operand A
issue_b  in  DATA_WIDTH  operand B
res_valid  in  1  ALU result valid this cycle
res_data  in  DATA_WIDTH  ALU result
res_carry  in  1  ALU carry/borrow flag
res_zero  in  1  ALU zero flag
pass_count  out  CNT_WIDTH  matching results
fail_count  out  CNT_WIDTH  mismatching results
skip_count  out  CNT_WIDTH  results for reserved opcodes (not compared)
outstanding  out  $clog2(DEPTH)+1  FIFO occupancy
err_overflow  out  1  sticky: issue lost because FIFO was full
err_underflow  out  1  sticky: result arrived with nothing outstanding
mismatch_seen  out  1  sticky: at least one fail
first_exp  out  DATA_WIDTH+2  {carry, zero, data} expected at the first fail
first_got  out  DATA_WIDTH+2  {carry, zero, data} received at the first fail
state  out  2  checker_state_t

Behaviour:
- Reset (async, reset_n=0): all counters 0, FIFO empty, outstanding 0, every err/mismatch flag 0, first_exp and first_got 0, state IDLE.
- Golden model (combinational at issue, result truncated to DATA_WIDTH):
  - 0 ADD: a+b, carry = bit DATA_WIDTH of the sum.
  - 1 SUB: a-b, carry = (a<b) as borrow.
  - 2 AND, 3 OR, 4 XOR: carry=0.
  - 5 NOT: ~a, carry=0.
  - 6 SHL: a<<1, carry = a[MSB].
  - 7 SHR: a>>1, carry = a[0].
  - zero = (result==0).
  - 8-15 reserved: entry is pushed with skip=1.
- Push: occurs when issue_valid && (!full || pop_this_cycle). If issue_valid && full && !pop, nothing is pushed and err_overflow is set.
- Pop: occurs when res_valid && !empty. Empty is judged on the registered occupancy, so a same-cycle push into an empty FIFO does not satisfy that cycle's result: underflow is set and the push still happens.
- Compare (on pop, results registered; counters visible 1 cycle after res_valid):
  - skip=1: skip_count++.
  - {carry, zero, data} equal: pass_count++.
  - else: fail_count++ and mismatch_seen=1. first_exp/first_got are loaded only if mismatch_seen was 0.
- Counters saturate at all-ones and never wrap. FIFO pointers wrap modulo DEPTH.
- Simultaneous push+pop at full or non-empty: occupancy unchanged, order preserved.
- clear=1: same effect as reset on the next edge, and has priority over push and pop in that cycle.
- State machine (registered, updated with the counters):
  - IDLE(0): occupancy 0, no error. Goes to ACTIVE on push.
  - ACTIVE(1): goes to IDLE when occupancy returns to 0. Goes to ERROR on fail, overflow or underflow.
  - DRAIN(2): not used by this revision; the encoding is reserved.
  - ERROR(3): sticky until clear or reset. Pushes, pops and counting continue.
- Reset asserted mid-operation: all in-flight expectations are discarded immediately.

Decomposition:
- pkg_testbench_defs gains:
  - alu_op_t enum (ALU_ADD..ALU_SHR, 4-bit).
  - checker_state_t enum.
  - ALU_DATA_WIDTH constant.
  - exp_entry_t packed struct {skip, carry, zero, data}.
- Sub-module alu_expect_fifo: synchronous FIFO of exp_entry_t with push/pop/full/empty/count. It is instantiated once. The golden model stays in alu_result_checker as a function.

Test Plan:
- ADD a=8'hF0 b=8'h20, res 8'h10 c=1 z=0 two cycles later -> pass_count=1, state returns to IDLE, outstanding 0.
- SUB a=3 b=5, res 8'hFE c=0 -> fail_count=1, mismatch_seen=1, first_exp=10'h2FE, first_got=10'h0FE, state=ERROR; a later fail leaves first_* unchanged.
- 9 issues with no results at DEPTH=8 -> outstanding=8, err_overflow=1. Then 8 correct results -> pass_count=8, outstanding=0.
- res_valid with FIFO empty -> err_underflow=1, no counter changes. Then clear -> all zero, state IDLE.
- Full FIFO with issue and result in the same cycle -> no overflow, outstanding stays 8, order preserved (a distinct XOR of 8'hAA^8'h55 = 8'hFF checked last).
- Opcode 12 issued then any result -> skip_count=1. reset_n pulsed low mid-stream with 3 outstanding -> outputs zero asynchronously, outstanding 0.
